md_iteration_controller: RTL and testbench



---
 rtl/md_iteration_controller.sv | 172 +++++++++++++++++
 tb/tb_md_iteration_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_iteration_controller.sv
// md_iteration_controller
//
// Top-level timestep sequencer for the range-limited MD core. A run covers
// num_iterations timesteps. Each timestep goes through five phases:
//   1. iter_start is pulsed to the broadcast controller.
//   2. The controller waits until every PE has finished reading.
//   3. The force write-back path must stay quiet for DRAIN_CYCLES
//      consecutive cycles, so that packets still in flight can land.
//   4. motion_update_start is pulsed.
//   5. The controller waits for MU_done.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   start                           run request (level or pulse), IDLE only
//   num_iterations [ITER_WIDTH]     timesteps to run, latched on accepted start
//   reading_done   [NUM_CELLS]      per-PE reading finished
//   filter_buffer_empty [NUM_CELLS] per-PE filter buffers empty
//   force_valid    [NUM_CELLS]      per-PE force write-back valid
//   force_cache_input_buffer_empty  all force-cache input buffers empty
//   MU_done                         motion-update completion pulse
//   iter_start                      1-cycle pulse, cycle spent in LAUNCH
//   motion_update_start             1-cycle pulse, cycle spent in MU_START
//   busy                            high whenever the FSM is not in IDLE
//   run_done                        1-cycle pulse, cycle spent in DONE
//   iter_count     [ITER_WIDTH]     completed timesteps of current/last run
//   ctrl_state     [3]              encoded FSM state (debug)
module md_iteration_controller #(
  parameter int NUM_CELLS       = 64,
  parameter int ITER_WIDTH      = 16,
  parameter int DRAIN_CYCLES    = 8,
  parameter int DRAIN_CNT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] num_iterations,
  input  logic [NUM_CELLS-1:0]  reading_done,
  input  logic [NUM_CELLS-1:0]  filter_buffer_empty,
  input  logic [NUM_CELLS-1:0]  force_valid,
  input  logic                  force_cache_input_buffer_empty,
  input  logic                  MU_done,
  output logic                  iter_start,
  output logic                  motion_update_start,
  output logic                  busy,
  output logic                  run_done,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic [2:0]            ctrl_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LAUNCH   = 3'd1,
    S_EVAL     = 3'd2,
    S_DRAIN    = 3'd3,
    S_MU_START = 3'd4,
    S_MU       = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [DRAIN_CNT_WIDTH-1:0] DRAIN_LAST = DRAIN_CNT_WIDTH'(DRAIN_CYCLES - 1);

  state_t                     state_q, state_d;
  logic                       rd_all_q, quiet_q, mu_done_q;
  logic [ITER_WIDTH-1:0]      target_q, target_d;
  logic [ITER_WIDTH-1:0]      iter_count_q, iter_count_d;
  logic [ITER_WIDTH-1:0]      iter_inc;
  logic [1:0]                 arm_q, arm_d, arm_inc;
  logic [DRAIN_CNT_WIDTH-1:0] drain_cnt_q, drain_cnt_d;

  assign iter_inc = iter_count_q + ITER_WIDTH'(1);
  // The arm counter saturates at 2.
  assign arm_inc  = (arm_q == 2'd2) ? 2'd2 : arm_q + 2'd1;

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    iter_count_d = iter_count_q;
    arm_d        = arm_q;
    drain_cnt_d  = drain_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          target_d     = num_iterations;
          iter_count_d = '0;
          state_d      = (num_iterations == '0) ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        arm_d   = 2'd0;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        // arm_inc counts EVAL cycles including the current one. rd_all is
        // not trusted before the second EVAL cycle, which hides a
        // reading_done left over from the previous timestep while the
        // broadcast controller clears it.
        arm_d = arm_inc;
        if (arm_inc == 2'd2 && rd_all_q) begin
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Any non-quiet sample restarts the full quiet window.
        if (!quiet_q) begin
          drain_cnt_d = '0;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_MU_START;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_CNT_WIDTH'(1);
        end
      end
      S_MU_START: begin
        state_d = S_MU;
      end
      S_MU: begin
        // An equality compare against the target means the counter never
        // wraps, even when the target is the all-ones value.
        if (mu_done_q) begin
          iter_count_d = iter_inc;
          state_d      = (iter_inc == target_q) ? S_DONE : S_LAUNCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= S_IDLE;
      rd_all_q            <= 1'b0;
      quiet_q             <= 1'b0;
      mu_done_q           <= 1'b0;
      target_q            <= '0;
      iter_count_q        <= '0;
      arm_q               <= '0;
      drain_cnt_q         <= '0;
      iter_start          <= 1'b0;
      motion_update_start <= 1'b0;
      busy                <= 1'b0;
      run_done            <= 1'b0;
      ctrl_state          <= '0;
    end else begin
      // Status inputs are registered once, and the FSM acts only on these
      // registered copies.
      rd_all_q            <= &reading_done;
      quiet_q             <= (&filter_buffer_empty) & force_cache_input_buffer_empty
                             & ~(|force_valid);
      mu_done_q           <= MU_done;
      state_q             <= state_d;
      target_q            <= target_d;
      iter_count_q        <= iter_count_d;
      arm_q               <= arm_d;
      drain_cnt_q         <= drain_cnt_d;
      // Outputs are decoded from the next state so that each output
      // register lines up with the state it describes.
      iter_start          <= (state_d == S_LAUNCH);
      motion_update_start <= (state_d == S_MU_START);
      run_done            <= (state_d == S_DONE);
      busy                <= (state_d != S_IDLE);
      ctrl_state          <= state_d;
    end
  end

  assign iter_count = iter_count_q;

endmodule

// File: tb/tb_md_iteration_controller.sv
// Testbench for md_iteration_controller. Input schedules are planned from
// the start cycle onward. Expected output pulses (cycle, kind, iter_count,
// state) go into a queue, and a monitor thread pops and compares them
// whenever the DUT raises a pulse output.
module tb_md_iteration_controller;

  localparam int NC = 64;
  localparam int IW = 16;
  localparam int DC = 8;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] num_iterations;
  logic [NC-1:0] reading_done;
  logic [NC-1:0] filter_buffer_empty;
  logic [NC-1:0] force_valid;
  logic          force_cache_input_buffer_empty;
  logic          MU_done;
  logic          iter_start;
  logic          motion_update_start;
  logic          busy;
  logic          run_done;
  logic [IW-1:0] iter_count;
  logic [2:0]    ctrl_state;

  md_iteration_controller #(
    .NUM_CELLS(NC), .ITER_WIDTH(IW), .DRAIN_CYCLES(DC), .DRAIN_CNT_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_iterations(num_iterations),
    .reading_done(reading_done), .filter_buffer_empty(filter_buffer_empty),
    .force_valid(force_valid),
    .force_cache_input_buffer_empty(force_cache_input_buffer_empty),
    .MU_done(MU_done), .iter_start(iter_start),
    .motion_update_start(motion_update_start), .busy(busy),
    .run_done(run_done), .iter_count(iter_count), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int kind;   // 1 iter_start, 2 motion_update_start, 4 run_done
    int cnt;
    int st;
  } ev_t;
  ev_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Input schedule, interpreted per cycle by tick().
  bit          init_rst;
  int          s_start, s_repulse, rst_cyc, mu_cyc, mu_spur;
  bit          s_hold;
  logic [IW-1:0] s_num;
  int          rd_lo, rd_hi, q_lo, q_hi, glitch_cyc, nq_kind, nq_bit;
  logic [NC-1:0] rd_partial;

  function automatic bit quiet_at(input int t);
    return !((t >= q_lo && t < q_hi) || t == glitch_cyc);
  endfunction

  task automatic push(input int c, input int k, input int n, input int st);
    ev_t e;
    e.cyc = c; e.kind = k; e.cnt = n; e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs applied at the falling edge of cycle cyc are sampled at the end
  // of that cycle.
  task automatic tick();
    @(negedge clk);
    rst   = init_rst || (cyc == rst_cyc);
    start = s_hold ? (cyc >= s_start) : (cyc == s_start || cyc == s_repulse);
    num_iterations = (cyc == s_start) ? s_num : IW'($urandom);
    reading_done   = (cyc >= rd_lo && cyc < rd_hi) ? rd_partial : '1;
    filter_buffer_empty = '1;
    force_valid = '0;
    force_cache_input_buffer_empty = 1'b1;
    if (!quiet_at(cyc)) begin
      case (nq_kind)
        0:       force_valid[nq_bit] = 1'b1;
        1:       filter_buffer_empty[nq_bit] = 1'b0;
        default: force_cache_input_buffer_empty = 1'b0;
      endcase
    end
    MU_done = (cyc == mu_cyc) || (cyc == mu_spur);
  endtask

  task automatic tick_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic idle_gap(input int len, input int exp_cnt);
    repeat (len) begin
      tick();
      check("idle_state", int'(ctrl_state), 0);
      check("idle_busy", int'(busy), 0);
      check("idle_iter_count", int'(iter_count), exp_cnt);
    end
  endtask

  // mode 0: random, 1: rd 20 cycles after iter_start and MU_done 10 cycles
  // later, 2: single force_valid glitch in DRAIN plus ignored start/MU_done.
  task automatic do_run(input int s, input int n, input bit hold, input int mode,
                        input int abort_iter, output int x_end);
    int L, R, qlen, K, D, M, m, goff;
    bit spur, rep, glitch, ok;
    s_start = s; s_num = IW'(n); s_hold = hold; s_repulse = -1;
    rst_cyc = -1; mu_cyc = -1; mu_spur = -1; glitch_cyc = -1;
    $display("run: start cycle %0d num_iterations %0d hold %0d mode %0d", s, n, hold, mode);
    if (n == 0) begin
      push(s + 1, 4, 0, 6);
      tick_until(s + 1);
      x_end = s + 1;
      return;
    end
    L = s + 1;
    for (int i = 0; i < n; i++) begin
      push(L, 1, i, 1);
      case (mode)
        1: begin R = 20; qlen = 0; glitch = 0; goff = 0; K = 10; spur = 0; rep = 0; nq_kind = 0; end
        2: begin R = 0; qlen = 0; glitch = 1; goff = 5; K = 3; spur = 1; rep = 1; nq_kind = 0; end
        default: begin
          R = int'($urandom_range(0, 25));
          qlen = int'($urandom_range(0, R + 12));
          glitch = 1'($urandom_range(0, 1));
          goff = int'($urandom_range(0, 9));
          K = int'($urandom_range(0, 12));
          spur = 1'($urandom_range(0, 1));
          rep = 1'($urandom_range(0, 1));
          nq_kind = int'($urandom_range(0, 2));
        end
      endcase
      nq_bit = int'($urandom_range(0, NC - 1));
      rd_partial = {$urandom, $urandom};
      rd_partial[$urandom_range(0, NC - 1)] = 1'b0;
      rd_lo = L; rd_hi = L + R;
      q_lo = L;  q_hi = L + qlen;
      // EVAL occupies at least two cycles; reading_done raised in cycle
      // L+R becomes visible to the FSM one cycle later.
      D = L + 3;
      if (L + R + 2 > D) D = L + R + 2;
      glitch_cyc = glitch ? D + goff : -1;
      // First cycle whose preceding DC registered samples, all taken in
      // DRAIN, were quiet (input sampled one cycle before the registered copy).
      M = D + DC;
      ok = 0;
      while (!ok && M < D + 1000) begin
        ok = 1;
        for (int t = M - DC - 1; t <= M - 2; t++) if (!quiet_at(t)) ok = 0;
        if (!ok) M++;
      end
      push(M, 2, i, 4);
      s_repulse = rep ? L + 1 : -1;
      if (i == abort_iter) begin
        rst_cyc = M + 1;
        tick_until(M + 2);
        check("abort_state", int'(ctrl_state), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_pulses", int'({run_done, motion_update_start, iter_start}), 0);
        check("abort_iter_count", int'(iter_count), 0);
        x_end = M + 2;
        return;
      end
      m = M + K;
      mu_cyc = m;
      mu_spur = spur ? D + 1 : -1;
      tick_until(m);
      L = m + 2;
    end
    push(L, 4, n, 6);
    tick_until(L);
    x_end = L;
  endtask

  task automatic monitor();
    ev_t e;
    int kind;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_event: got no pulse by cycle %0d, expected kind %0d at cycle %0d",
                 cyc, exp_q[0].kind, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      kind = int'({run_done, motion_update_start, iter_start});
      if (kind != 0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no pulse", kind, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.kind != kind || e.cnt != int'(iter_count) ||
              e.st != int'(ctrl_state) || busy != 1'b1) begin
            n_fail++;
            $display("FAIL event: got cycle %0d kind %0d iter_count %0d state %0d busy %0d, expected cycle %0d kind %0d iter_count %0d state %0d busy 1",
                     cyc, kind, iter_count, ctrl_state, busy, e.cyc, e.kind, e.cnt, e.st);
          end else begin
            $display("cycle %0d: pulse kind %0d iter_count %0d state %0d ok", cyc, kind, iter_count, ctrl_state);
          end
        end
      end
    end
  endtask

  initial begin
    int x, n;
    init_rst = 1; s_start = -1; s_repulse = -1; s_hold = 0; s_num = '0;
    rst_cyc = -1; mu_cyc = -1; mu_spur = -1; glitch_cyc = -1;
    rd_lo = 0; rd_hi = 0; q_lo = 0; q_hi = 0; nq_kind = 0; nq_bit = 0; rd_partial = '0;
    rst = 1; start = 0; num_iterations = '0; reading_done = '1;
    filter_buffer_empty = '1; force_valid = '0;
    force_cache_input_buffer_empty = 1'b1; MU_done = 0;
    fork
      monitor();
    join_none

    repeat (3) tick();
    check("reset_state", int'(ctrl_state), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_pulses", int'({run_done, motion_update_start, iter_start}), 0);
    check("reset_iter_count", int'(iter_count), 0);
    init_rst = 0;

    do_run(cyc + 2, 3, 0, 1, -1, x);      // three full timesteps
    idle_gap(4, 3);
    do_run(cyc + 1, 0, 0, 0, -1, x);      // zero-length run
    idle_gap(3, 0);
    do_run(cyc + 1, 2, 0, 2, -1, x);      // drain glitch, ignored start/MU_done
    idle_gap(2, 2);
    do_run(cyc + 1, 3, 0, 0, 1, x);       // reset while in MU
    idle_gap(2, 0);
    do_run(cyc + 1, 1, 0, 0, -1, x);      // normal run after the abort
    idle_gap(2, 1);
    do_run(cyc + 1, 2, 1, 0, -1, x);      // level start held through DONE
    do_run(x + 1, 1, 0, 0, -1, x);        // picked up right after DONE
    idle_gap(2, 1);
    for (int r = 0; r < 10; r++) begin
      n = int'($urandom_range(0, 4));
      do_run(cyc + 1 + int'($urandom_range(0, 3)), n, 0, 0, -1, x);
      idle_gap(2, n);
    end

    repeat (5) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
